prog_loader: RTL and testbench

Byte-stream program loader. It receives a framed program image, packs the bytes into 32-bit words and writes them into instruction memory, which the fetcher later reads. Byte order is the inverse of the fetcher/top-level byte reversal: the first byte of each word lands in bits [31:24]. While a load is in progress the block holds the CPU (fetcher/executor) stalled.

---
 rtl/prog_loader.sv | 143 ++++++++++++++
 tb/tb_prog_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte-stream program image, packs payload
// bytes big-endian into 32-bit words and writes them to instruction memory.
// Holds the CPU stalled from frame start until a frame completes with a good
// checksum.
module prog_loader #(
   parameter int          ADDR_W     = 8,
   parameter logic [7:0]  START_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_written
);

   // Memory capacity in bytes; frames longer than this are rejected up front
   // so the word address can never wrap inside a frame.
   localparam int unsigned CAP = 4 * (2 ** ADDR_W);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WR, S_CSUM
   } state_t;

   state_t      state;
   logic [7:0]  len_hi;
   logic [7:0]  acc;
   logic [15:0] remain;
   logic [1:0]  lane;

   logic        xfer;
   logic [15:0] len_full;
   logic [7:0]  csum_sum;
   logic        len_too_big;

   // Handshake and frame-level arithmetic on the byte currently offered
   always_comb begin
      xfer        = in_valid & in_ready;
      len_full    = {len_hi, in_data};
      csum_sum    = acc + in_data;
      len_too_big = 32'(len_full) > CAP;
   end

   // Frame parser FSM; all outputs registered. mem_wdata doubles as the word
   // assembly register, so it already holds the packed word during WR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         in_ready      <= 1'b1;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         cpu_hold      <= 1'b0;
         load_done     <= 1'b0;
         load_err      <= 1'b0;
         words_written <= '0;
         len_hi        <= '0;
         acc           <= '0;
         remain        <= '0;
         lane          <= '0;
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         mem_we    <= 1'b0;
         case (state)
            S_IDLE: begin
               // Non-start bytes are consumed and dropped
               if (xfer && in_data == START_BYTE) begin
                  state         <= S_LEN_HI;
                  cpu_hold      <= 1'b1;
                  words_written <= '0;
                  mem_addr      <= '0;
                  acc           <= '0;
                  lane          <= '0;
               end
            end
            S_LEN_HI: begin
               if (xfer) begin
                  len_hi <= in_data;
                  state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (xfer) begin
                  remain <= len_full;
                  if (len_too_big) begin
                     load_err <= 1'b1;
                     state    <= S_IDLE;
                  end else if (len_full == 16'd0) begin
                     state <= S_CSUM;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  acc    <= csum_sum;
                  remain <= remain - 16'd1;
                  lane   <= lane + 2'd1;
                  case (lane)
                     2'd0:    mem_wdata          <= {in_data, 24'h000000};
                     2'd1:    mem_wdata[23:16]   <= in_data;
                     2'd2:    mem_wdata[15:8]    <= in_data;
                     default: mem_wdata[7:0]     <= in_data;
                  endcase
                  if (lane == 2'd3 || remain == 16'd1) begin
                     state    <= S_WR;
                     mem_we   <= 1'b1;
                     in_ready <= 1'b0;
                  end
               end
            end
            S_WR: begin
               in_ready      <= 1'b1;
               lane          <= '0;
               mem_addr      <= mem_addr + 1'b1;
               words_written <= words_written + 1'b1;
               state         <= (remain == 16'd0) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
               if (xfer) begin
                  if (csum_sum == 8'h00) begin
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     load_err <= 1'b1;
                  end
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader (ADDR_W=2, 16-byte memory): directed frames plus
// randomized frames scored against a byte-level model of the frame format.
module tb_prog_loader;
   localparam int AW  = 2;
   localparam int CAP = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          load_done;
   logic          load_err;
   logic [AW:0]   words_written;

   prog_loader #(.ADDR_W(AW), .START_BYTE(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
      .load_err(load_err), .words_written(words_written)
   );

   always #5 clk = ~clk;

   int total = 0;
   int pass_cnt = 0;

   logic [AW+31:0] wq[$];
   int  done_cnt = 0, err_cnt = 0, rdy_low = 0;
   bit  prev_done = 0, prev_err = 0;
   bit  exp_hold = 0;
   logic [7:0] pl [0:31];

   // Observe memory writes and pulses; in_ready must be low exactly when writing
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we) wq.push_back({mem_addr, mem_wdata});
         if (load_done) done_cnt++;
         if (load_err) err_cnt++;
         if (!in_ready) rdy_low++;
         total++;
         if (in_ready !== !mem_we) $display("FAIL rdy_vs_we: in_ready=%b mem_we=%b", in_ready, mem_we);
         else pass_cnt++;
         if (load_done || load_err) begin
            total++;
            if ((prev_done && load_done) || (prev_err && load_err))
               $display("FAIL pulse_width: done=%b err=%b held over 1 cycle", load_done, load_err);
            else pass_cnt++;
         end
         prev_done = load_done;
         prev_err  = load_err;
      end else begin
         prev_done = 0;
         prev_err  = 0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok = 0;
      in_data  = b;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (!ok) begin
         total++;
         $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] good_cs(input int len);
      int s = 0;
      for (int i = 0; i < len; i++) s += pl[i];
      return 8'((256 - (s % 256)) % 256);
   endfunction

   // Send one frame and score it against the frame-format model
   task automatic run_frame(input int len, input logic [7:0] cs, input int gap, input string nm);
      logic [AW+31:0] exp_q[$];
      logic [31:0]    w;
      logic [AW-1:0]  a;
      int  sum, nw, idx;
      bit  good;
      wq.delete();
      done_cnt = 0; err_cnt = 0; rdy_low = 0;

      sum = cs;
      for (int i = 0; i < len && i < 32; i++) sum += pl[i];
      good = (len <= CAP) && (sum % 256 == 0);
      nw   = (len <= CAP) ? (len + 3) / 4 : 0;
      for (int wi = 0; wi < nw; wi++) begin
         w = 32'h0;
         for (int k = 0; k < 4; k++) begin
            idx = 4 * wi + k;
            if (idx < len) w[31 - 8 * k -: 8] = pl[idx];
         end
         a = wi[AW-1:0];
         exp_q.push_back({a, w});
      end

      send_byte(8'hA5);
      send_byte(8'(len >> 8));
      send_byte(8'(len));
      if (len <= CAP) begin
         for (int i = 0; i < len; i++) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send_byte(pl[i]);
         end
         if (gap > 0) idle($urandom_range(0, gap));
         send_byte(cs);
      end
      @(negedge clk);
      total++;
      if ({load_done, load_err} !== {good, !good})
         $display("FAIL %s pulse_timing: done/err=%b%b want %b%b", nm, load_done, load_err, good, !good);
      else pass_cnt++;
      idle(4);
      exp_hold = !good;

      total++;
      if (wq.size() !== nw) $display("FAIL %s write_count: got %0d want %0d", nm, wq.size(), nw);
      else pass_cnt++;
      for (int i = 0; i < nw && i < wq.size(); i++) begin
         total++;
         if (wq[i] !== exp_q[i]) $display("FAIL %s write%0d: got %h want %h", nm, i, wq[i], exp_q[i]);
         else pass_cnt++;
      end
      total++;
      if (done_cnt !== int'(good) || err_cnt !== int'(!good))
         $display("FAIL %s pulses: done=%0d err=%0d want %0d %0d", nm, done_cnt, err_cnt, good, !good);
      else pass_cnt++;
      total++;
      if (words_written !== (AW+1)'(nw)) $display("FAIL %s words_written: got %0d want %0d", nm, words_written, nw);
      else pass_cnt++;
      total++;
      if (cpu_hold !== exp_hold) $display("FAIL %s cpu_hold: got %b want %b", nm, cpu_hold, exp_hold);
      else pass_cnt++;
      total++;
      if (rdy_low !== nw) $display("FAIL %s ready_low_cycles: got %0d want %0d", nm, rdy_low, nw);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(3);
      total++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_written} !==
          {1'b1, 1'b0, {AW{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b0, {(AW+1){1'b0}}})
         $display("FAIL reset_values: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b ww=%h",
                  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_written);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      exp_hold = 0;
      idle(2);
   endtask

   task automatic test_single_word();
      pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF;
      run_frame(4, good_cs(4), 0, "deadbeef");
   endtask

   task automatic test_two_words();
      for (int i = 0; i < 6; i++) pl[i] = 8'(i + 1);
      run_frame(6, 8'hEB, 0, "two_words");
      run_frame(6, 8'h00, 0, "bad_csum");
      pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30; pl[3] = 8'h40;
      run_frame(4, good_cs(4), 0, "after_err");
   endtask

   task automatic test_garbage();
      wq.delete();
      send_byte(8'h11);
      send_byte(8'h22);
      idle(3);
      total++;
      if (wq.size() !== 0 || cpu_hold !== exp_hold)
         $display("FAIL garbage_drop: writes=%0d hold=%b want 0 %b", wq.size(), cpu_hold, exp_hold);
      else pass_cnt++;
      run_frame(0, 8'h00, 0, "empty_frame");
   endtask

   task automatic test_len_bounds();
      for (int i = 0; i < 17; i++) pl[i] = 8'($urandom);
      run_frame(17, 8'h00, 0, "len_over");
      run_frame(16, good_cs(16), 0, "len_full");
   endtask

   task automatic test_reset_midframe();
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h08);
      send_byte(8'h01);
      send_byte(8'h02);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_written} !==
          {1'b1, 1'b0, {AW{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b0, {(AW+1){1'b0}}})
         $display("FAIL midframe_reset: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b ww=%h",
                  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_written);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      exp_hold = 0;
      idle(2);
      for (int i = 0; i < 8; i++) pl[i] = 8'hA0 + 8'(i);
      run_frame(8, good_cs(8), 0, "after_reset");
   endtask

   task automatic test_random();
      int len;
      logic [7:0] cs;
      for (int f = 0; f < 20; f++) begin
         len = $urandom_range(0, CAP);
         for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
         cs = ($urandom_range(0, 3) != 0) ? good_cs(len) : 8'($urandom);
         run_frame(len, cs, 3, "random");
         if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'hA4)));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_word();
      test_two_words();
      test_garbage();
      test_len_bounds();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
